// File: rtl/sofa_plus_scan_ctrl.sv
// Scan-chain shift controller: loads a word, shifts it LSB-first into the chain, then pulses done.
// Optional readback of the prior chain contents through SO is enabled by SOFA_PLUS_SCAN_READBACK_EN.
module sofa_plus_scan_ctrl #(
  parameter int CHAIN_LEN = 16,
  parameter int CNT_W     = 8
) (
  input  logic                 C,
  input  logic                 R,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CHAIN_LEN-1:0] load_data,
  input  logic                 SO,
  output logic                 Test_en,
  output logic                 DI,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic [CHAIN_LEN-1:0] rdata
);

  // One-hot encoding lets every status output be a single flop bit or its inverse.
  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    SHIFT = 3'b010,
    DONE  = 3'b100
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [CHAIN_LEN-1:0] shreg;
  logic [CNT_W-1:0]     cnt;
  logic                 last_bit;

  assign last_bit = (cnt == CNT_W'(CHAIN_LEN - 1));

  // State register
  always_ff @(posedge C or posedge R) begin
    if (R) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; abort outranks the completion transition
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (last_bit) begin
          state_nxt = DONE;
        end else begin
          state_nxt = SHIFT;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Shift register, bit counter and sticky abort flag
  always_ff @(posedge C or posedge R) begin
    if (R) begin
      shreg   <= '0;
      cnt     <= '0;
      aborted <= 1'b0;
    end else if (state == IDLE && start) begin
      shreg   <= load_data;
      cnt     <= '0;
      aborted <= 1'b0;
    end else if (state == SHIFT) begin
      shreg <= {1'b0, shreg[CHAIN_LEN-1:1]};
      cnt   <= cnt + CNT_W'(1);
      if (abort) begin
        aborted <= 1'b1;
      end else begin
        aborted <= aborted;
      end
    end else begin
      shreg   <= shreg;
      cnt     <= cnt;
      aborted <= aborted;
    end
  end

  assign Test_en = state[1];
  assign done    = state[2];
  assign busy    = ~state[0];
  assign DI      = shreg[0];

`ifdef SOFA_PLUS_SCAN_READBACK_EN
  // Tail-flop data enters at the MSB so the first bit out lands at bit 0 after a full pass.
  always_ff @(posedge C or posedge R) begin
    if (R) begin
      rdata <= '0;
    end else if (state == SHIFT) begin
      rdata <= {SO, rdata[CHAIN_LEN-1:1]};
    end else begin
      rdata <= rdata;
    end
  end
`else
  logic unused_so;
  assign unused_so = SO;
  assign rdata     = '0;
`endif

endmodule

// File: tb/tb_sofa_plus_scan_ctrl.sv
// Directed testbench for sofa_plus_scan_ctrl with a 4-flop behavioral scan chain.
module tb_sofa_plus_scan_ctrl;
  localparam int CL = 4;

  logic          C;
  logic          R;
  logic          start;
  logic          abort;
  logic [CL-1:0] load_data;
  logic          SO;
  logic          Test_en;
  logic          DI;
  logic          busy;
  logic          done;
  logic          aborted;
  logic [CL-1:0] rdata;

  logic [CL-1:0] chain;
  logic          preload_en;
  logic [CL-1:0] preload_val;

  int tests;
  int fails;

  sofa_plus_scan_ctrl #(.CHAIN_LEN(CL), .CNT_W(3)) dut (
    .C(C), .R(R), .start(start), .abort(abort), .load_data(load_data), .SO(SO),
    .Test_en(Test_en), .DI(DI), .busy(busy), .done(done), .aborted(aborted), .rdata(rdata)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  // Behavioral chain: head flop is bit CL-1, tail (SO) is bit 0
  always @(posedge C) begin
    if (preload_en) chain <= preload_val;
    else if (Test_en) chain <= {DI, chain[CL-1:1]};
  end
  assign SO = chain[0];

  function automatic logic [CL-1:0] exp_rd(input logic [CL-1:0] v);
`ifdef SOFA_PLUS_SCAN_READBACK_EN
    return v;
`else
    return 4'b0000;
`endif
  endfunction

  task automatic tick();
    @(posedge C);
    #1;
  endtask

  task automatic preload(input logic [CL-1:0] v);
    preload_en  = 1'b1;
    preload_val = v;
    tick();
    preload_en  = 1'b0;
  endtask

  task automatic test_reset();
    #7;
    tests++; if ({Test_en, DI, busy, done, aborted} !== 5'b00000) begin fails++; $display("FAIL reset_outs got %b want 00000", {Test_en, DI, busy, done, aborted}); end
    tests++; if (rdata !== 4'b0000) begin fails++; $display("FAIL reset_rdata got %b want 0000", rdata); end
    @(negedge C);
    R = 1'b0;
    tick();
    tick();
    tests++; if ({Test_en, DI, busy, done} !== 4'b0000) begin fails++; $display("FAIL post_reset_idle got %b want 0000", {Test_en, DI, busy, done}); end
  endtask

  task automatic test_shift();
    logic [CL-1:0] pat;
    pat = 4'b1011;
    preload(4'b0110);
    load_data = pat;
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      tests++; if (Test_en !== (c <= 4)) begin fails++; $display("FAIL shift_test_en c%0d got %b want %b", c, Test_en, (c <= 4)); end
      tests++; if (busy !== (c <= 5)) begin fails++; $display("FAIL shift_busy c%0d got %b want %b", c, busy, (c <= 5)); end
      tests++; if (done !== (c == 5)) begin fails++; $display("FAIL shift_done c%0d got %b want %b", c, done, (c == 5)); end
      if (c <= 4) begin
        tests++; if (DI !== pat[c-1]) begin fails++; $display("FAIL shift_di c%0d got %b want %b", c, DI, pat[c-1]); end
      end
      if (c == 6) begin
        tests++; if (rdata !== exp_rd(4'b0110)) begin fails++; $display("FAIL readback1 got %b want %b", rdata, exp_rd(4'b0110)); end
        tests++; if (chain !== 4'b1011) begin fails++; $display("FAIL chain1 got %b want 1011", chain); end
        tests++; if (aborted !== 1'b0) begin fails++; $display("FAIL shift_aborted got %b want 0", aborted); end
      end
      start     = (c == 2) || (c == 5) || (c == 6);
      load_data = (c == 6) ? 4'b0101 : 4'b0000;
      tick();
    end
    start = 1'b0;
    tests++; if ({Test_en, DI} !== 2'b11) begin fails++; $display("FAIL restart_c7 got %b want 11", {Test_en, DI}); end
    tick(); tick(); tick(); tick();
    tests++; if ({done, Test_en} !== 2'b10) begin fails++; $display("FAIL restart_done got %b want 10", {done, Test_en}); end
    tick();
    tests++; if (rdata !== exp_rd(4'b1011)) begin fails++; $display("FAIL readback2 got %b want %b", rdata, exp_rd(4'b1011)); end
    tests++; if (chain !== 4'b0101) begin fails++; $display("FAIL chain2 got %b want 0101", chain); end
  endtask

  task automatic test_abort();
    preload(4'b0101);
    load_data = 4'b1110;
    start     = 1'b1;
    tick();
    start = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tests++; if ({Test_en, busy, done, aborted} !== 4'b0001) begin fails++; $display("FAIL abort_c3 got %b want 0001", {Test_en, busy, done, aborted}); end
    tests++; if (rdata !== exp_rd(4'b0110)) begin fails++; $display("FAIL abort_partial got %b want %b", rdata, exp_rd(4'b0110)); end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if ({done, Test_en} !== 2'b00) begin fails++; $display("FAIL abort_quiet i%0d got %b want 00", i, {done, Test_en}); end
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tests++; if ({busy, aborted} !== 2'b01) begin fails++; $display("FAIL abort_idle got %b want 01", {busy, aborted}); end
    load_data = 4'b1011;
    start     = 1'b1;
    abort     = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    tests++; if ({Test_en, aborted} !== 2'b10) begin fails++; $display("FAIL start_abort_same got %b want 10", {Test_en, aborted}); end
    tick(); tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tests++; if ({done, busy, aborted} !== 3'b001) begin fails++; $display("FAIL abort_last got %b want 001", {done, busy, aborted}); end
    tick();
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL abort_last_nodone got %b want 0", done); end
  endtask

  task automatic test_reset_mid();
    load_data = 4'b0111;
    start     = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tests++; if ({Test_en, DI, busy} !== 3'b111) begin fails++; $display("FAIL pre_reset_c3 got %b want 111", {Test_en, DI, busy}); end
    #2;
    R = 1'b1;
    #1;
    tests++; if ({Test_en, DI, busy, done, aborted} !== 5'b00000) begin fails++; $display("FAIL async_reset got %b want 00000", {Test_en, DI, busy, done, aborted}); end
    tests++; if (rdata !== 4'b0000) begin fails++; $display("FAIL async_reset_rdata got %b want 0000", rdata); end
    @(negedge C);
    R = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++; if ({done, busy, aborted} !== 3'b000) begin fails++; $display("FAIL post_reset_quiet i%0d got %b want 000", i, {done, busy, aborted}); end
    end
  endtask

  initial begin
    tests       = 0;
    fails       = 0;
    R           = 1'b1;
    start       = 1'b0;
    abort       = 1'b0;
    load_data   = '0;
    preload_en  = 1'b0;
    preload_val = '0;
    test_reset();
    test_shift();
    test_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sofa_plus_scan_ctrl.md
SOFA_PLUS_SCAN_CTRL -- requirements
Module: sofa_plus_scan_ctrl

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 16, number of sofa_plus flip-flops in the controlled scan chain (2..256).
REQ-002 SHALL have parameter CNT_W, default 8, width of the shift counter; 2**CNT_W SHALL be >= CHAIN_LEN.
REQ-003 C  input  1  single clock; all state changes on rising edge.
REQ-004 R  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request to shift load_data into the chain; sampled only in IDLE.
REQ-006 abort  input  1  cancel an in-progress shift.
REQ-007 load_data  input  CHAIN_LEN  word to shift into the chain; bit 0 is shifted first.
REQ-008 SO  input  1  serial output of the chain tail flop.
REQ-009 Test_en  output  1  scan-enable to every chain flop.
REQ-010 DI  output  1  scan data into the chain head flop.
REQ-011 busy  output  1  high in SHIFT and DONE.
REQ-012 done  output  1  one-cycle pulse on successful completion.
REQ-013 aborted  output  1  sticky flag, set by abort, cleared by next accepted start.
REQ-014 rdata  output  CHAIN_LEN  prior chain contents captured during the shift.

Function
REQ-015 SHALL implement states IDLE, SHIFT, DONE, held in a register.
REQ-016 IDLE with start=1 at an edge: capture load_data into shift register, clear counter, clear aborted, go to SHIFT.
REQ-017 start outside IDLE SHALL be ignored with no side effect, including start in the DONE cycle.
REQ-018 Test_en SHALL be 1 exactly while state is SHIFT, decoded from the state register only.
REQ-019 DI SHALL equal shift-register bit 0; each SHIFT edge shifts right by one and increments the counter.
REQ-020 After CHAIN_LEN SHIFT cycles (counter = CHAIN_LEN-1 at the edge), next state SHALL be DONE.
REQ-021 Latency: start sampled at edge k -> Test_en high for cycles k+1..k+CHAIN_LEN, done high in cycle k+CHAIN_LEN+1, IDLE at k+CHAIN_LEN+2.
REQ-022 DONE SHALL last exactly one cycle, assert done, then return to IDLE.
REQ-023 abort=1 in SHIFT: next state IDLE, aborted set, done not asserted, Test_en low next cycle; chain contents are partial.
REQ-024 abort in IDLE or DONE SHALL be ignored; abort has priority over the REQ-020 completion transition.
REQ-025 Simultaneous start and abort in IDLE: start accepted, abort ignored.
REQ-026 Outputs DI, done, busy, Test_en SHALL be glitch-free, derived directly from flops.

Reset
REQ-027 R=1 SHALL immediately force state IDLE, counter 0, shift register 0, rdata 0, aborted 0.
REQ-028 During and after reset until next start: Test_en=0, DI=0, busy=0, done=0.
REQ-029 Reset asserted mid-SHIFT SHALL abandon the shift with no done pulse; aborted stays 0.

Configuration
REQ-030 Macro SOFA_PLUS_SCAN_READBACK_EN SHALL select readback.
REQ-031 Defined: each SHIFT edge shifts SO into rdata from the MSB side (rdata <= {SO, rdata[CHAIN_LEN-1:1]}); after done, rdata holds the chain's previous contents, tail flop at bit 0.
REQ-032 Defined: rdata SHALL be held unchanged in IDLE/DONE and after abort holds the partial capture.
REQ-033 Not defined: rdata SHALL be constant 0, SO unused, and no rdata flops synthesized.

Verification
REQ-034 CHAIN_LEN=4, load_data=4'b1011, start at edge 0 -> DI=1,1,0,1 in cycles 1-4 with Test_en=1; done=1 in cycle 5 only; busy cycles 1-5.
REQ-035 start pulsed in cycles 2 and 5 of the REQ-034 run -> ignored; DI sequence and done timing unchanged; next start accepted in cycle 6.
REQ-036 abort=1 in cycle 2 -> Test_en=0 from cycle 3, state IDLE, aborted=1, done never 1; next start clears aborted.
REQ-037 R=1 in cycle 3 of a shift -> Test_en, DI, busy drop to 0 immediately without waiting for C; no done; aborted=0.
REQ-038 With SOFA_PLUS_SCAN_READBACK_EN, behavioral 4-flop chain preloaded 4'b0110 and load_data=4'b1011 -> rdata=4'b0110 after done and chain holds 4'b1011; without macro rdata=0.
